// File: rtl/pipelined_mult_unit.sv
// ---------------------------------------------------------------------------
// pipelined_mult_unit
//   Pipelined integer multiplier for the Tomasulo MUL path. It takes one
//   operand pair per cycle from the MUL reservation station, together with
//   its RS tag, and returns the full 2*WIDTH product with that tag to the CDB
//   arbiter STAGES edges after the accept edge.
//
//   Structure: an input register (stage 0) followed by STAGES reduction
//   stages (pmu_stage). Stage k adds the partial product for one CH-bit
//   chunk of the multiplier, so the valid bits form vld_pipe[STAGES:0].
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     operand handshake (in_ready = !stall && !flush)
//     in_a, in_b            operands, WIDTH bits
//     in_signed             1: two's-complement operands, 0: unsigned
//     in_tag                RS tag carried with the operation
//     flush                 drop every in-flight op, including a stalled output
//     out_valid/out_ready   product handshake toward the CDB arbiter
//     out_product, out_tag  2*WIDTH product and its tag
// ---------------------------------------------------------------------------

// One reduction stage: acc_o = acc_i + (a_i * chunk) << SH, where chunk is
// b_i[SH +: CH]. Arithmetic is modulo 2^DW, which is exact for the product.
module pmu_stage #(
  parameter int DW    = 64,
  parameter int TAG_W = 4,
  parameter int CH    = 22,
  parameter int SH    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  logic [DW-1:0]    acc_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [DW-1:0]    acc_o
);
  localparam logic [DW-1:0] CH_MASK = {DW{1'b1}} >> (DW - CH);

  logic [DW-1:0] chunk;
  logic [DW-1:0] pp;

  always_comb begin
    chunk = (b_i >> SH) & CH_MASK;
    pp    = a_i * chunk;
  end

  // Data registers only load under a valid op, so a bubble leaves the
  // previous contents in place (the output holds its last value).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      tag_o <= '0;
      acc_o <= '0;
    end else if (clr) begin
      vld_o <= 1'b0;
    end else if (en) begin
      vld_o <= vld_i;
      if (vld_i) begin
        tag_o <= tag_i;
        acc_o <= acc_i + (pp << SH);
      end
    end
  end
endmodule

module pipelined_mult_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int DW = 2 * WIDTH;
  // Multiplier bits reduced per stage; STAGES*CH covers all DW bits.
  localparam int CH = (DW + STAGES - 1) / STAGES;

  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][TAG_W-1:0]   tag_pipe;
  logic [STAGES:0][DW-1:0]      acc_pipe;
  logic [STAGES-1:0][DW-1:0]    a_pipe;
  logic [STAGES-1:0][DW-1:0]    b_pipe;

  logic stall;
  logic adv;

  assign stall     = vld_pipe[STAGES] && !out_ready;
  assign adv       = !stall;
  assign in_ready  = !stall && !flush;

  assign out_valid   = vld_pipe[STAGES];
  assign out_product = acc_pipe[STAGES];
  assign out_tag     = tag_pipe[STAGES];

  // Stage 0: capture the op. The signed/unsigned mode is consumed here by
  // extending both operands to DW bits; after that the low DW bits of the
  // product are mode-independent, so no mode bit needs to travel further.
  logic             s0_vld;
  logic [TAG_W-1:0] s0_tag;
  logic [DW-1:0]    s0_a;
  logic [DW-1:0]    s0_b;
  logic [DW-1:0]    a_ext;
  logic [DW-1:0]    b_ext;

  always_comb begin
    a_ext = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
    b_ext = {{WIDTH{in_signed & in_b[WIDTH-1]}}, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
      s0_tag <= '0;
      s0_a   <= '0;
      s0_b   <= '0;
    end else if (flush) begin
      s0_vld <= 1'b0;
    end else if (adv) begin
      s0_vld <= in_valid;
      if (in_valid) begin
        s0_tag <= in_tag;
        s0_a   <= a_ext;
        s0_b   <= b_ext;
      end
    end
  end

  assign vld_pipe[0] = s0_vld;
  assign tag_pipe[0] = s0_tag;
  assign acc_pipe[0] = '0;
  assign a_pipe[0]   = s0_a;
  assign b_pipe[0]   = s0_b;

  genvar k;
  generate
    for (k = 1; k <= STAGES; k = k + 1) begin : g_stg
      pmu_stage #(
        .DW   (DW),
        .TAG_W(TAG_W),
        .CH   (CH),
        .SH   ((k - 1) * CH)
      ) u_stg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .clr  (flush),
        .vld_i(vld_pipe[k-1]),
        .tag_i(tag_pipe[k-1]),
        .a_i  (a_pipe[k-1]),
        .b_i  (b_pipe[k-1]),
        .acc_i(acc_pipe[k-1]),
        .vld_o(vld_pipe[k]),
        .tag_o(tag_pipe[k]),
        .acc_o(acc_pipe[k])
      );

      // Operands ride along until the last reduction stage has used them.
      if (k < STAGES) begin : g_fwd
        logic [DW-1:0] a_q;
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
          end else if (adv && !flush && vld_pipe[k-1]) begin
            a_q <= a_pipe[k-1];
            b_q <= b_pipe[k-1];
          end
        end
        assign a_pipe[k] = a_q;
        assign b_pipe[k] = b_q;
      end
    end
  endgenerate
endmodule
